// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares one single-port synchronous data RAM between the
// pipeline MEM stage (port 0, high priority) and a secondary requester
// (port 1). A starvation guard forces one port-1 access after STARVE_LIMIT
// consecutive denied cycles. Read data returns one cycle after acceptance.
module dm_port_arbiter #(
    parameter int unsigned AW           = 16,
    parameter int unsigned DW           = 16,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CW           = 8
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,

    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [0:0] ST_NORM  = 1'b0;
    localparam logic [0:0] ST_FORCE = 1'b1;

    // Limit widened by one bit so wait_cnt + 1 never wraps when compared.
    localparam logic [CW:0] LIMIT = (CW + 1)'(STARVE_LIMIT);

    logic [0:0]    state;
    logic [0:0]    state_next;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_cnt_next;
    logic [CW:0]   cnt_inc;
    logic          p0_acc;
    logic          p1_acc;
    logic          rd_owner0;
    logic          rd_owner1;

    assign cnt_inc = {1'b0, wait_cnt} + {{CW{1'b0}}, 1'b1};
    assign p0_acc  = p0_req & p0_gnt;
    assign p1_acc  = p1_req & p1_gnt;

    // Grant decode: port 0 wins in ST_NORM, port 1 owns the RAM in ST_FORCE.
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!reset) begin
            if (state == ST_FORCE) begin
                p1_gnt = p1_req;
            end else begin
                p0_gnt = p0_req;
                p1_gnt = p1_req & ~p0_req;
            end
        end
    end

    // Starvation counter and state next-value logic.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;

        if (!p1_req || p1_acc) begin
            wait_cnt_next = '0;
        end else if ({1'b0, wait_cnt} < LIMIT) begin
            wait_cnt_next = cnt_inc[CW-1:0];
        end

        if (state == ST_NORM) begin
            if (p1_req && !p1_gnt && (cnt_inc >= LIMIT)) begin
                state_next = ST_FORCE;
            end
        end else begin
            // A dropped request abandons the forced slot.
            if (p1_acc || !p1_req) begin
                state_next = ST_NORM;
            end
        end
    end

    // Arbiter state and read-owner registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_NORM;
            wait_cnt  <= '0;
            rd_owner0 <= 1'b0;
            rd_owner1 <= 1'b0;
        end else begin
            state     <= state_next;
            wait_cnt  <= wait_cnt_next;
            rd_owner0 <= p0_acc & ~p0_we;
            rd_owner1 <= p1_acc & ~p1_we;
        end
    end

    // RAM pin mux: idle pins are driven to zero so mem_we cannot leak.
    always_comb begin
        mem_en    = p0_gnt | p1_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (p1_gnt) begin
            mem_we    = p1_we;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
        end else if (p0_gnt) begin
            mem_we    = p0_we;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
        end
    end

    // Read return steering; gated by reset so a read accepted just before
    // reset never reports valid data.
    always_comb begin
        p0_rvalid = rd_owner0 & ~reset;
        p1_rvalid = rd_owner1 & ~reset;
        p0_rdata  = p0_rvalid ? mem_rdata : '0;
        p1_rdata  = p1_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed self-checking bench for dm_port_arbiter with a behavioural RAM.
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [15:0] p0_rdata, p1_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata;

    logic [15:0] ram [0:255];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dm_port_arbiter #(
        .AW(16), .DW(16), .STARVE_LIMIT(4), .CW(8)
    ) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Single-port synchronous RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[7:0]];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive0(input logic req, input logic we, input logic [15:0] a,
                          input logic [15:0] d);
        p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d;
    endtask

    task automatic drive1(input logic req, input logic we, input logic [15:0] a,
                          input logic [15:0] d);
        p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d;
    endtask

    logic       e_p0g [0:4];
    logic       e_p1g [0:4];
    logic       e_p0v [0:4];
    logic       e_p1v [0:4];

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
        mem_rdata = 16'h0000;
        reset = 1'b1;
        drive0(1'b0, 1'b0, 16'h0, 16'h0);
        drive1(1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        tick();
        settle();
        check_val("rst_p0_rvalid", {31'b0, p0_rvalid}, 32'h0);
        check_val("rst_p1_rvalid", {31'b0, p1_rvalid}, 32'h0);
        check_val("rst_p0_rdata", {16'b0, p0_rdata}, 32'h0);
        check_val("rst_mem_en", {31'b0, mem_en}, 32'h0);
        check_val("rst_wait_cnt", {24'b0, dut.wait_cnt}, 32'h0);

        // 1: p0 write then read back
        tick();
        reset = 1'b0;
        drive0(1'b1, 1'b1, 16'h0010, 16'h00A5);
        settle();
        check_val("t1_wr_gnt", {31'b0, p0_gnt}, 32'h1);
        check_val("t1_wr_mem_we", {31'b0, mem_we}, 32'h1);
        check_val("t1_wr_addr", {16'b0, mem_addr}, 32'h0010);
        tick();
        drive0(1'b1, 1'b0, 16'h0010, 16'h0000);
        settle();
        check_val("t1_rd_gnt", {31'b0, p0_gnt}, 32'h1);
        check_val("t1_wr_no_rvalid", {31'b0, p0_rvalid}, 32'h0);
        tick();
        drive0(1'b0, 1'b0, 16'h0, 16'h0);
        settle();
        check_val("t1_rvalid", {31'b0, p0_rvalid}, 32'h1);
        check_val("t1_rdata", {16'b0, p0_rdata}, 32'h00A5);
        check_val("t1_p1_rvalid", {31'b0, p1_rvalid}, 32'h0);
        check_val("t1_p1_rdata", {16'b0, p1_rdata}, 32'h0);
        tick();
        settle();
        check_val("t1_rvalid_one", {31'b0, p0_rvalid}, 32'h0);

        // 2: p1 alone write then read back
        tick();
        drive1(1'b1, 1'b1, 16'h0020, 16'h1234);
        settle();
        check_val("t2_wr_gnt", {31'b0, p1_gnt}, 32'h1);
        tick();
        drive1(1'b1, 1'b0, 16'h0020, 16'h0000);
        settle();
        check_val("t2_rd_gnt", {31'b0, p1_gnt}, 32'h1);
        tick();
        drive1(1'b0, 1'b0, 16'h0, 16'h0);
        settle();
        check_val("t2_rvalid", {31'b0, p1_rvalid}, 32'h1);
        check_val("t2_rdata", {16'b0, p1_rdata}, 32'h1234);
        tick();

        // 3: both held, port 1 forced every fifth cycle
        drive0(1'b1, 1'b0, 16'h0040, 16'h0);
        drive1(1'b1, 1'b0, 16'h0041, 16'h0);
        for (int i = 0; i < 10; i++) begin
            settle();
            check_val($sformatf("t3_p0_gnt_%0d", i), {31'b0, p0_gnt},
                      (i % 5 == 4) ? 32'h0 : 32'h1);
            check_val($sformatf("t3_p1_gnt_%0d", i), {31'b0, p1_gnt},
                      (i % 5 == 4) ? 32'h1 : 32'h0);
            check_val($sformatf("t3_cnt_%0d", i), {24'b0, dut.wait_cnt}, 32'(i % 5));
            tick();
        end
        drive0(1'b0, 1'b0, 16'h0, 16'h0);
        drive1(1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        tick();

        // 4: p0 write and p1 read to the same address in one cycle
        drive0(1'b1, 1'b1, 16'h0030, 16'hBEEF);
        drive1(1'b1, 1'b0, 16'h0030, 16'h0000);
        settle();
        check_val("t4_p0_first", {31'b0, p0_gnt}, 32'h1);
        check_val("t4_p1_wait", {31'b0, p1_gnt}, 32'h0);
        tick();
        drive0(1'b0, 1'b0, 16'h0, 16'h0);
        settle();
        check_val("t4_p1_next", {31'b0, p1_gnt}, 32'h1);
        tick();
        drive1(1'b0, 1'b0, 16'h0, 16'h0);
        settle();
        check_val("t4_rvalid", {31'b0, p1_rvalid}, 32'h1);
        check_val("t4_rdata", {16'b0, p1_rdata}, 32'hBEEF);
        tick();

        // 5: read accepted right before reset is dropped; held p1 re-arbitrated
        drive0(1'b1, 1'b0, 16'h0010, 16'h0);
        settle();
        check_val("t5_p0_gnt", {31'b0, p0_gnt}, 32'h1);
        tick();
        reset = 1'b1;
        drive0(1'b0, 1'b0, 16'h0, 16'h0);
        drive1(1'b1, 1'b0, 16'h0020, 16'h0);
        for (int i = 0; i < 2; i++) begin
            settle();
            check_val($sformatf("t5_rst_rvalid_%0d", i), {31'b0, p0_rvalid}, 32'h0);
            check_val($sformatf("t5_rst_p1_gnt_%0d", i), {31'b0, p1_gnt}, 32'h0);
            check_val($sformatf("t5_rst_mem_en_%0d", i), {31'b0, mem_en}, 32'h0);
            check_val($sformatf("t5_rst_mem_we_%0d", i), {31'b0, mem_we}, 32'h0);
            tick();
        end
        reset = 1'b0;
        settle();
        check_val("t5_post_p1_gnt", {31'b0, p1_gnt}, 32'h1);
        check_val("t5_post_p0_rvalid", {31'b0, p0_rvalid}, 32'h0);
        tick();
        drive1(1'b0, 1'b0, 16'h0, 16'h0);
        settle();
        check_val("t5_p1_rvalid", {31'b0, p1_rvalid}, 32'h1);
        check_val("t5_p1_rdata", {16'b0, p1_rdata}, 32'h1234);
        tick();

        // 6: preload, then alternating reads
        drive0(1'b1, 1'b1, 16'h0001, 16'h0011);
        tick();
        drive0(1'b1, 1'b1, 16'h0002, 16'h0022);
        tick();
        drive0(1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        e_p0g = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        e_p1g = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        e_p0v = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        e_p1v = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            drive0(e_p0g[i], 1'b0, 16'h0001, 16'h0);
            drive1(e_p1g[i], 1'b0, 16'h0002, 16'h0);
            settle();
            check_val($sformatf("t6_p0_gnt_%0d", i), {31'b0, p0_gnt}, {31'b0, e_p0g[i]});
            check_val($sformatf("t6_p1_gnt_%0d", i), {31'b0, p1_gnt}, {31'b0, e_p1g[i]});
            check_val($sformatf("t6_both_%0d", i), {31'b0, p0_gnt & p1_gnt}, 32'h0);
            check_val($sformatf("t6_mem_we_%0d", i), {31'b0, mem_we}, 32'h0);
            check_val($sformatf("t6_p0_rv_%0d", i), {31'b0, p0_rvalid}, {31'b0, e_p0v[i]});
            check_val($sformatf("t6_p1_rv_%0d", i), {31'b0, p1_rvalid}, {31'b0, e_p1v[i]});
            check_val($sformatf("t6_p0_rd_%0d", i), {16'b0, p0_rdata},
                      e_p0v[i] ? 32'h0011 : 32'h0);
            check_val($sformatf("t6_p1_rd_%0d", i), {16'b0, p1_rdata},
                      e_p1v[i] ? 32'h0022 : 32'h0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
